// File: rtl/video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_generator
// Purpose  : Pixel coordinates, DE, syncs and one-hot pattern select for the
//            SXGA panel; AUTO_PATTERN_CYCLE_EN adds frame-count auto stepping.
// Revision : 1.0
// ============================================================================
module video_timing_generator #(
  parameter int unsigned H_ACTIVE           = 1280,
  parameter int unsigned H_FP               = 48,
  parameter int unsigned H_SYNC             = 112,
  parameter int unsigned H_BP               = 248,
  parameter int unsigned V_ACTIVE           = 1024,
  parameter int unsigned V_FP               = 1,
  parameter int unsigned V_SYNC             = 3,
  parameter int unsigned V_BP               = 38,
  parameter logic        SYNC_POL           = 1'b1,
  parameter int unsigned FRAMES_PER_PATTERN = 120
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        PatternNext,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        DE,
  output logic        HSync,
  output logic        VSync,
  output logic        FrameStart,
  output logic [3:0]  ImageState
);

  localparam logic [11:0] c_h_fp     = 12'(H_FP);
  localparam logic [11:0] c_hs_end   = 12'(H_FP + H_SYNC);
  localparam logic [11:0] c_h_blank  = 12'(H_FP + H_SYNC + H_BP);
  localparam logic [11:0] c_h_tot    = 12'(H_FP + H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
  localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] c_v_tot    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  localparam logic [0:0] c_idle    = 1'b0;
  localparam logic [0:0] c_pending = 1'b1;

  logic [11:0] r_hcnt;
  logic [11:0] r_vcnt;
  logic        r_run;
  logic [11:0] w_hnext;
  logic [11:0] w_vnext;
  logic        w_hact;
  logic        w_vact;
  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic        w_step;
  logic        w_auto_due;

  // The first clock after reset release presents (0,0) so FrameStart is not lost.
  always_comb begin
    w_hnext = 12'd0;
    w_vnext = 12'd0;
    if (r_run) begin
      if (r_hcnt == c_h_tot - 12'd1) begin
        w_hnext = 12'd0;
        w_vnext = (r_vcnt == c_v_tot - 12'd1) ? 12'd0 : r_vcnt + 12'd1;
      end else begin
        w_hnext = r_hcnt + 12'd1;
        w_vnext = r_vcnt;
      end
    end
  end

  assign w_hact = (w_hnext >= c_h_blank);
  assign w_vact = (w_vnext < c_v_active);

  // Outputs are registered from the next counter values so they line up with the counters.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_run      <= 1'b0;
      r_hcnt     <= 12'd0;
      r_vcnt     <= 12'd0;
      x          <= 12'hfff;
      y          <= 12'hfff;
      DE         <= 1'b0;
      HSync      <= ~SYNC_POL;
      VSync      <= ~SYNC_POL;
      FrameStart <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_hcnt     <= w_hnext;
      r_vcnt     <= w_vnext;
      x          <= (w_hact && w_vact) ? (w_hnext - c_h_blank) : 12'hfff;
      y          <= w_vact ? w_vnext : 12'hfff;
      DE         <= w_hact && w_vact;
      HSync      <= ((w_hnext >= c_h_fp) && (w_hnext < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
      VSync      <= ((w_vnext >= c_vs_start) && (w_vnext < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
      FrameStart <= (w_hnext == 12'd0) && (w_vnext == 12'd0);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A request seen on the FrameStart cycle is applied immediately, so it never goes pending.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:    if (PatternNext && !FrameStart) w_state_next = c_pending;
      c_pending: if (FrameStart) w_state_next = c_idle;
      default:   w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_step = 1'b0;
    if (FrameStart) begin
      w_step = (r_state == c_pending) || PatternNext || w_auto_due;
    end
  end

`ifdef AUTO_PATTERN_CYCLE_EN
  localparam int unsigned c_fw = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [c_fw-1:0] c_f_last = c_fw'(FRAMES_PER_PATTERN - 1);

  logic [c_fw-1:0] r_fcnt;

  assign w_auto_due = (r_fcnt == c_f_last);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_fcnt <= '0;
    end else if (w_step) begin
      r_fcnt <= '0;
    end else if (FrameStart) begin
      r_fcnt <= r_fcnt + c_fw'(1);
    end
  end
`else
  logic w_unused_fpp;

  assign w_auto_due   = 1'b0;
  assign w_unused_fpp = (FRAMES_PER_PATTERN != 0);
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ImageState <= 4'b0001;
    end else if (w_step) begin
      ImageState <= {ImageState[2:0], ImageState[3]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_generator
// Purpose  : Scoreboard bench for video_timing_generator on a 14x7 raster.
// Revision : 1.0
// ============================================================================
module tb_video_timing_generator;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        PatternNext;
  logic [11:0] x;
  logic [11:0] y;
  logic        DE;
  logic        HSync;
  logic        VSync;
  logic        FrameStart;
  logic [3:0]  ImageState;

  always #5 Clock = ~Clock;

  video_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FRAMES_PER_PATTERN(3)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .PatternNext(PatternNext),
    .x(x), .y(y), .DE(DE), .HSync(HSync), .VSync(VSync),
    .FrameStart(FrameStart), .ImageState(ImageState)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [3:0]  img;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  exp_t m_got;
  int   checks = 0;
  int   errors = 0;
  int   n_de   = 0;
  int   n_fs   = 0;
  int   n_pop  = 0;
  int   exp_de = 0;
  int   exp_fs = 0;

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = 12'hfff; e.y = 12'hfff; e.de = 1'b0;
    e.hs = 1'b0; e.vs = 1'b0; e.fs = 1'b0; e.img = 4'b0001;
    return e;
  endfunction

  // Raster of the bench geometry: 6 blanking clocks then 8 pixels per line,
  // lines 0..3 active, line 5 is the VSync line.
  function automatic exp_t frame_exp(input int off, input logic [3:0] img_fs,
                                     input logic [3:0] img_rest);
    exp_t e;
    int h;
    int v;
    h = off % 14;
    v = off / 14;
    e.x   = (v < 4 && h >= 6) ? 12'(h - 6) : 12'hfff;
    e.y   = (v < 4) ? 12'(v) : 12'hfff;
    e.de  = (v < 4 && h >= 6);
    e.hs  = (h == 2 || h == 3);
    e.vs  = (v == 5);
    e.fs  = (off == 0);
    e.img = (off == 0) ? img_fs : img_rest;
    return e;
  endfunction

  task automatic reset_cycle(input logic release_now);
    @(posedge Clock);
    #1;
    PatternNext = 1'b0;
    ResetN = release_now;
    q.push_back(reset_exp());
  endtask

  task automatic run_frame(input logic [3:0] img_fs, input logic [3:0] img_rest,
                           input int pn_a, input int pn_b, input int rst_at);
    for (int off = 0; off < 98; off++) begin
      @(posedge Clock);
      #1;
      if (off == rst_at) begin
        ResetN = 1'b0;
        PatternNext = 1'b0;
        q.push_back(reset_exp());
        return;
      end
      PatternNext = (off == pn_a) || (off == pn_b);
      q.push_back(frame_exp(off, img_fs, img_rest));
    end
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_got = '{x: x, y: y, de: DE, hs: HSync, vs: VSync, fs: FrameStart, img: ImageState};
      checks++;
      n_pop++;
      n_de = n_de + int'(DE);
      n_fs = n_fs + int'(FrameStart);
      if (m_got !== m_e) begin
        errors++;
        $display("FAIL sample %0d: got x=%h y=%h de=%b hs=%b vs=%b fs=%b img=%b, want x=%h y=%h de=%b hs=%b vs=%b fs=%b img=%b",
                 n_pop, x, y, DE, HSync, VSync, FrameStart, ImageState,
                 m_e.x, m_e.y, m_e.de, m_e.hs, m_e.vs, m_e.fs, m_e.img);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  initial begin
    ResetN = 1'b0;
    PatternNext = 1'b0;
    reset_cycle(1'b0);
    reset_cycle(1'b0);
    reset_cycle(1'b1);

`ifdef AUTO_PATTERN_CYCLE_EN
    run_frame(4'b0001, 4'b0001, -1, -1, -1);
    run_frame(4'b0001, 4'b0001, -1, -1, -1);
    run_frame(4'b0001, 4'b0010, -1, -1, -1);
    run_frame(4'b0010, 4'b0010, 40, -1, -1);
    run_frame(4'b0010, 4'b0100, -1, -1, -1);
    run_frame(4'b0100, 4'b0100, -1, -1, -1);
    run_frame(4'b0100, 4'b0100, -1, -1, -1);
    run_frame(4'b0100, 4'b1000, -1, -1, -1);
    exp_de = 8 * 32;
    exp_fs = 8;
`else
    run_frame(4'b0001, 4'b0001, -1, -1, -1);
    run_frame(4'b0001, 4'b0001, 40, -1, -1);
    run_frame(4'b0001, 4'b0010, 10, 50, -1);
    run_frame(4'b0010, 4'b0100, 20, -1, -1);
    run_frame(4'b0100, 4'b1000, 30, -1, -1);
    run_frame(4'b1000, 4'b0001, -1, -1, -1);
    run_frame(4'b0001, 4'b0010, 0, -1, -1);
    run_frame(4'b0010, 4'b0010, 5, -1, -1);
    // Reset lands at hcnt 9, vcnt 2 while ImageState is 0100.
    run_frame(4'b0010, 4'b0100, -1, -1, 37);
    reset_cycle(1'b0);
    reset_cycle(1'b1);
    run_frame(4'b0001, 4'b0001, -1, -1, -1);
    exp_de = 8 * 32 + 19 + 32;
    exp_fs = 10;
`endif

    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    checks++;
    if (n_de != exp_de) begin
      errors++;
      $display("FAIL de_count: got %0d, want %0d", n_de, exp_de);
    end
    checks++;
    if (n_fs != exp_fs) begin
      errors++;
      $display("FAIL fs_count: got %0d, want %0d", n_fs, exp_fs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
